// File: rtl/elevator_call_register_if.sv
// Button / call-request bundle between the car panel front end and the
// elevator sequencing FSM. The master side drives the raw buttons and car
// status; the slave side (the call register) returns clean request levels.
interface elevator_call_register_if #(
  parameter int NUM_FLOORS = 8
);
  localparam int CNT_W = $clog2(NUM_FLOORS + 1);

  logic [NUM_FLOORS-1:0] btn_raw;
  logic                  open_raw;
  logic                  close_raw;
  logic                  door_open;
  logic [2:0]            car_floor;
  logic                  floor_valid;
  logic                  cancel_all;

  logic [NUM_FLOORS-1:0] req;
  logic                  open_cmd;
  logic                  close_cmd;
  logic                  req_any;
  logic [CNT_W-1:0]      req_count;

  modport master (
    output btn_raw, open_raw, close_raw, door_open, car_floor, floor_valid, cancel_all,
    input  req, open_cmd, close_cmd, req_any, req_count
  );

  modport slave (
    input  btn_raw, open_raw, close_raw, door_open, car_floor, floor_valid, cancel_all,
    output req, open_cmd, close_cmd, req_any, req_count
  );
endinterface

// File: rtl/elevator_call_register.sv
// Elevator call register: synchronises and debounces the car buttons, latches
// one call per floor on each fresh press, and drops a call once the car stands
// at that floor with the doors open. Door open/close requests pass through as
// debounced levels, with open taking precedence over close.
module elevator_call_register #(
  parameter int NUM_FLOORS      = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  elevator_call_register_if.slave     bus
);

  localparam int NIN   = NUM_FLOORS + 2;   // floor buttons, then open, then close
  localparam int CNT_W = $clog2(NUM_FLOORS + 1);
  localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0]        raw;
  logic [NIN-1:0]        s1;
  logic [NIN-1:0]        s2;
  logic [NIN-1:0]        db;
  logic [DB_W-1:0]       cnt [NIN];
  logic [NUM_FLOORS-1:0] db_q;

  logic [NUM_FLOORS-1:0] req_q;
  logic                  open_q;
  logic                  close_q;

  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [CNT_W-1:0]      pop;

  assign raw = {bus.close_raw, bus.open_raw, bus.btn_raw};

  // Two-flop synchroniser plus per-input debounce: db only follows s2 after
  // DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db[NUM_FLOORS-1:0];
      for (int i = 0; i < NIN; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_TC) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only a fresh debounced press sets a call, so a held button cannot
  // re-register a call that was served or cancelled while it was held.
  assign set_mask = db[NUM_FLOORS-1:0] & ~db_q;

  // Serve the floor the car is level at with doors open. Floors at or beyond
  // NUM_FLOORS never match a bit, so they clear nothing.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (bus.door_open && bus.floor_valid && (int'(bus.car_floor) == i)) clr_mask[i] = 1'b1;
    end
  end

  // Call latches and door commands; cancel beats clear beats set.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      open_q  <= 1'b0;
      close_q <= 1'b0;
    end else begin
      if (bus.cancel_all) req_q <= '0;
      else                req_q <= (req_q | set_mask) & ~clr_mask;
      open_q  <= db[NUM_FLOORS];
      close_q <= db[NUM_FLOORS+1] & ~db[NUM_FLOORS];
    end
  end

  // Popcount of the latched calls; combinational so it tracks req directly.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_FLOORS; i++) pop = pop + CNT_W'(req_q[i]);
  end

  assign bus.req       = req_q;
  assign bus.open_cmd  = open_q;
  assign bus.close_cmd = close_q;
  assign bus.req_any   = |req_q;
  assign bus.req_count = pop;

endmodule

// File: tb/tb_elevator_call_register.sv
// Directed bench for the elevator call register. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, so a press applied
// after edge k-1 is first seen by the synchroniser at edge k. Walking the
// debounce by hand (s1 at k, s2 at k+1, four mismatch samples at k+2..k+5)
// puts db at edge k+5 and the latched call at edge k+6.
module tb_elevator_call_register;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  elevator_call_register_if #(.NUM_FLOORS(8)) bus ();

  elevator_call_register #(
    .NUM_FLOORS(8),
    .DEBOUNCE_CYCLES(4),
    .DB_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.btn_raw     = '0;
    bus.open_raw    = 1'b0;
    bus.close_raw   = 1'b0;
    bus.door_open   = 1'b0;
    bus.car_floor   = '0;
    bus.floor_valid = 1'b0;
    bus.cancel_all  = 1'b0;

    // Reset state
    tick(3);
    rst = 1'b0;
    chk("rst_req",       32'(bus.req),       32'h00);
    chk("rst_open_cmd",  32'(bus.open_cmd),  32'h0);
    chk("rst_close_cmd", 32'(bus.close_cmd), 32'h0);
    chk("rst_req_any",   32'(bus.req_any),   32'h0);
    chk("rst_req_count", 32'(bus.req_count), 32'h0);

    // Floor 3 press held 10 cycles: call appears exactly at edge k+6
    bus.btn_raw[3] = 1'b1;
    tick(6);
    chk("f3_before_latency", 32'(bus.req), 32'h00);
    tick(1);
    chk("f3_latched",   32'(bus.req),       32'h08);
    chk("f3_count",     32'(bus.req_count), 32'h1);
    chk("f3_any",       32'(bus.req_any),   32'h1);
    tick(3);
    bus.btn_raw[3] = 1'b0;
    tick(8);
    chk("f3_held_after_release", 32'(bus.req), 32'h08);

    // Three-cycle glitch on floor 5 is filtered out
    bus.btn_raw[5] = 1'b1;
    tick(3);
    bus.btn_raw[5] = 1'b0;
    tick(10);
    chk("f5_glitch", 32'(bus.req), 32'h08);

    // Real floor 5 press -> 8'h28
    bus.btn_raw[5] = 1'b1;
    tick(8);
    bus.btn_raw[5] = 1'b0;
    tick(8);
    chk("f5_latched", 32'(bus.req),       32'h28);
    chk("f5_count",   32'(bus.req_count), 32'h2);

    // Doors open at floor 3 for one cycle clears floor 3 only
    bus.car_floor = 3'd3; bus.floor_valid = 1'b1; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    chk("clear_f3", 32'(bus.req), 32'h20);

    // Doors open at floor 5 but floor not valid: nothing clears
    bus.car_floor = 3'd5; bus.floor_valid = 1'b0; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    chk("clear_invalid", 32'(bus.req), 32'h20);

    // Floor 2 set edge coincides with doors open at floor 2 -> stays clear
    bus.btn_raw[2] = 1'b1;
    tick(6);
    bus.car_floor = 3'd2; bus.floor_valid = 1'b1; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    chk("set_clear_same_floor", 32'(bus.req), 32'h20);
    tick(5);
    chk("held_no_relatch", 32'(bus.req), 32'h20);
    bus.btn_raw[2] = 1'b0;
    tick(8);

    // Same set edge with doors open at floor 4 -> floor 2 latches
    bus.btn_raw[2] = 1'b1;
    tick(6);
    bus.car_floor = 3'd4; bus.floor_valid = 1'b1; bus.door_open = 1'b1;
    tick(1);
    bus.door_open = 1'b0;
    chk("set_other_floor", 32'(bus.req), 32'h24);
    bus.btn_raw[2] = 1'b0;
    bus.floor_valid = 1'b0;
    tick(8);

    // Open and close held together: open wins
    bus.open_raw = 1'b1; bus.close_raw = 1'b1;
    tick(10);
    chk("both_open_cmd",  32'(bus.open_cmd),  32'h1);
    chk("both_close_cmd", 32'(bus.close_cmd), 32'h0);
    bus.open_raw = 1'b0;
    tick(6);
    chk("close_before_latency", 32'(bus.close_cmd), 32'h0);
    tick(1);
    chk("close_after_release", 32'(bus.close_cmd), 32'h1);
    chk("open_after_release",  32'(bus.open_cmd),  32'h0);
    bus.close_raw = 1'b0;
    tick(8);
    chk("close_released", 32'(bus.close_cmd), 32'h0);

    // All floors called, then cancel_all
    bus.btn_raw = 8'hFF;
    tick(8);
    bus.btn_raw = 8'h00;
    tick(8);
    chk("all_req",   32'(bus.req),       32'hFF);
    chk("all_count", 32'(bus.req_count), 32'h8);
    bus.cancel_all = 1'b1;
    tick(1);
    bus.cancel_all = 1'b0;
    chk("cancel_req",   32'(bus.req),       32'h00);
    chk("cancel_count", 32'(bus.req_count), 32'h0);
    chk("cancel_any",   32'(bus.req_any),   32'h0);

    // Cancel while a button is still held: no re-latch
    bus.btn_raw[0] = 1'b1;
    tick(8);
    chk("f0_latched", 32'(bus.req), 32'h01);
    bus.cancel_all = 1'b1;
    tick(1);
    bus.cancel_all = 1'b0;
    tick(5);
    chk("cancel_held_no_relatch", 32'(bus.req), 32'h00);
    bus.btn_raw[0] = 1'b0;
    tick(8);

    // Reset mid-debounce of floor 1, with floor 6 already called
    bus.btn_raw[6] = 1'b1;
    tick(8);
    bus.btn_raw[6] = 1'b0;
    tick(8);
    chk("f6_latched", 32'(bus.req), 32'h40);
    bus.btn_raw[1] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("midrst_req",   32'(bus.req),       32'h00);
    chk("midrst_count", 32'(bus.req_count), 32'h0);
    rst = 1'b0;
    tick(6);
    chk("post_rst_before_latency", 32'(bus.req), 32'h00);
    tick(1);
    chk("post_rst_f1_latched", 32'(bus.req),       32'h02);
    chk("post_rst_f1_count",   32'(bus.req_count), 32'h1);
    bus.btn_raw[1] = 1'b0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
